// File: rtl/fetch_req_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_req_ctrl
//
// Purpose:
//   Consumer end of the PC interface. Accepts one PC at a time from the Pc
//   block, issues a single ICache request for it, waits for the matching
//   response and presents {pc, inst} to the decode buffer. While a fetch is
//   in progress PcStop holds the Pc block. A redirect (FlushAble) kills the
//   in-flight fetch. If the request was already accepted by the ICache, its
//   response is still owed, so it is waited for and then discarded.
//
// Ports:
//   Clk          in   clock, all state changes on posedge
//   Rest         in   synchronous reset, active-low
//   PcAble       in   PC valid from Pc block
//   PcDate       in   fetch PC from Pc block
//   FlushAble    in   redirect this cycle
//   PcStop       out  hold request to Pc block (busy)
//   IcReqAble    out  ICache request valid
//   IcReqAddr    out  ICache request address
//   IcReqReady   in   ICache accepts request
//   IcRespAble   in   ICache response valid (one cycle per accepted request)
//   IcRespInst   in   response instruction
//   DecStall     in   decode buffer full
//   FetchAble    out  fetched instruction valid to decode
//   FetchPc      out  PC of fetched instruction
//   FetchInst    out  fetched instruction
//   DbgState     out  current FSM state (IDLE=0, REQ=1, WAIT=2, HOLD=3)
//
// Handshakes (valid/ready):
//   A transfer happens on a posedge where valid and ready are both high.
//   Once valid is raised, it and its payload stay stable until that transfer.
//   - PC in : valid = PcAble, ready = !PcStop (and no flush that cycle).
//   - ICache: valid = IcReqAble, ready = IcReqReady.
//   - Decode: valid = FetchAble, ready = !DecStall.
// ---------------------------------------------------------------------------
module fetch_req_ctrl #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              Clk,
  input  logic              Rest,
  input  logic              PcAble,
  input  logic [ADDR_W-1:0] PcDate,
  input  logic              FlushAble,
  output logic              PcStop,
  output logic              IcReqAble,
  output logic [ADDR_W-1:0] IcReqAddr,
  input  logic              IcReqReady,
  input  logic              IcRespAble,
  input  logic [INST_W-1:0] IcRespInst,
  input  logic              DecStall,
  output logic              FetchAble,
  output logic [ADDR_W-1:0] FetchPc,
  output logic [INST_W-1:0] FetchInst,
  output logic [1:0]        DbgState
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_drop;
  logic              w_drop_nxt;
  logic              w_latch_pc;
  logic              w_capture;
  logic [ADDR_W-1:0] r_req_pc;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [INST_W-1:0] r_fetch_inst;

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (!Rest) begin
      r_state      <= ST_IDLE;
      r_drop       <= 1'b0;
      r_req_pc     <= '0;
      r_fetch_pc   <= '0;
      r_fetch_inst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      if (w_latch_pc) begin
        r_req_pc <= PcDate;
      end
      if (w_capture) begin
        r_fetch_pc   <= r_req_pc;
        r_fetch_inst <= IcRespInst;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_latch_pc  = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // A redirect in the same cycle means PcDate is about to change,
        // so the PC is not taken.
        if (PcAble && !FlushAble) begin
          w_latch_pc  = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (IcReqReady) begin
          // Once accepted, the ICache owes a response even if we are being
          // flushed, so remember to throw it away.
          w_drop_nxt  = FlushAble;
          w_state_nxt = ST_WAIT;
        end else if (FlushAble) begin
          // Not accepted yet: simply withdraw, nothing will come back.
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (IcRespAble) begin
          w_drop_nxt = 1'b0;
          if (r_drop || FlushAble) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end else if (FlushAble) begin
          w_drop_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        // Either decode took it, or the redirect also flushes decode.
        if (!DecStall || FlushAble) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign PcStop    = (r_state != ST_IDLE);
  assign IcReqAble = (r_state == ST_REQ);
  assign IcReqAddr = r_req_pc;
  assign FetchAble = (r_state == ST_HOLD);
  assign FetchPc   = r_fetch_pc;
  assign FetchInst = r_fetch_inst;
  assign DbgState  = r_state;

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_req_ctrl
//
// Bench for fetch_req_ctrl. A transaction-level reference tracks the single
// fetch in flight (accepted PC, whether the ICache took the request, whether
// a redirect killed it, whether a result is waiting for decode). From that it
// predicts the outputs every cycle. Delivered {pc, inst} pairs go through an
// expected queue. Directed scenarios come first, then a randomized run
// with a randomly delayed ICache responder.
// ---------------------------------------------------------------------------
module tb_fetch_req_ctrl;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int W      = ADDR_W + INST_W;

  logic              clk;
  logic              rest;
  logic              pc_able;
  logic [ADDR_W-1:0] pc_date;
  logic              flush_able;
  logic              pc_stop;
  logic              ic_req_able;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_req_ready;
  logic              ic_resp_able;
  logic [INST_W-1:0] ic_resp_inst;
  logic              dec_stall;
  logic              fetch_able;
  logic [ADDR_W-1:0] fetch_pc;
  logic [INST_W-1:0] fetch_inst;
  logic [1:0]        dbg_state;

  int n_chk = 0;
  int n_err = 0;
  int n_deliv = 0;

  fetch_req_ctrl #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .Clk        (clk),
    .Rest       (rest),
    .PcAble     (pc_able),
    .PcDate     (pc_date),
    .FlushAble  (flush_able),
    .PcStop     (pc_stop),
    .IcReqAble  (ic_req_able),
    .IcReqAddr  (ic_req_addr),
    .IcReqReady (ic_req_ready),
    .IcRespAble (ic_resp_able),
    .IcRespInst (ic_resp_inst),
    .DecStall   (dec_stall),
    .FetchAble  (fetch_able),
    .FetchPc    (fetch_pc),
    .FetchInst  (fetch_inst),
    .DbgState   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // One fetch transaction at a time.
  bit                m_busy;     // a PC has been taken and is not finished
  bit                m_issued;   // ICache has accepted the request
  bit                m_killed;   // a redirect hit after the request was accepted
  bit                m_have;     // result waiting for decode
  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W-1:0] m_fpc;
  logic [INST_W-1:0] m_finst;
  logic [W-1:0]      exp_q[$];
  bit                auto_on;
  bit                sb_seen;

  initial begin
    m_busy = 0; m_issued = 0; m_killed = 0; m_have = 0;
    m_pc = '0; m_fpc = '0; m_finst = '0;
    auto_on = 0; sb_seen = 0;
  end

  always @(posedge clk) begin
    if (!rest) begin
      m_busy = 0; m_issued = 0; m_killed = 0; m_have = 0;
      m_pc = '0; m_fpc = '0; m_finst = '0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (pc_able && !flush_able) begin
        m_busy = 1; m_issued = 0; m_killed = 0; m_have = 0;
        m_pc = pc_date;
      end
    end else if (!m_issued) begin
      if (ic_req_ready) begin
        m_issued = 1;
        m_killed = flush_able;
      end else if (flush_able) begin
        m_busy = 0;
      end
    end else if (!m_have) begin
      if (ic_resp_able) begin
        if (m_killed || flush_able) begin
          m_busy = 0;
        end else begin
          m_have  = 1;
          m_fpc   = m_pc;
          m_finst = ic_resp_inst;
          exp_q.push_back({m_pc, ic_resp_inst});
        end
      end else if (flush_able) begin
        m_killed = 1;
      end
    end else begin
      if (!dec_stall || flush_able) begin
        m_busy = 0;
        m_have = 0;
      end
    end
  end

  // Per-cycle output comparison plus delivery scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (auto_on) begin
      check_eq("pc_stop",   pc_stop,     m_busy);
      check_eq("req_able",  ic_req_able, m_busy && !m_issued);
      check_eq("req_addr",  ic_req_addr, m_pc);
      check_eq("fetch_able", fetch_able, m_have);
      check_eq("fetch_pc",  fetch_pc,    m_fpc);
      check_eq("fetch_inst", fetch_inst, m_finst);
      check_eq("state", dbg_state,
               !m_busy ? 2'd0 : (!m_issued ? 2'd1 : (!m_have ? 2'd2 : 2'd3)));
      if (fetch_able && !sb_seen) begin
        sb_seen = 1;
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected", 1, 0);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check_eq("sb_deliv", {fetch_pc, fetch_inst}, e);
          n_deliv++;
        end
      end
      if (!fetch_able) sb_seen = 0;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    pc_able = 0; flush_able = 0; ic_req_ready = 0;
    ic_resp_able = 0; dec_stall = 0;
  endtask

  // ---------------- stimulus ----------------
  bit                r_pend;
  int                r_lat;
  logic [INST_W-1:0] r_inst;

  initial begin
    rest = 0; pc_date = '0; ic_resp_inst = '0;
    idle_inputs();

    // Test 1: reset
    next_cyc(); next_cyc();
    rest = 1;
    auto_on = 1;
    next_cyc();
    check_eq("rst_pc_stop", pc_stop, 0);
    check_eq("rst_req_able", ic_req_able, 0);
    check_eq("rst_req_addr", ic_req_addr, 0);
    check_eq("rst_fetch_able", fetch_able, 0);
    check_eq("rst_fetch_pc", fetch_pc, 0);
    check_eq("rst_fetch_inst", fetch_inst, 0);
    check_eq("rst_state", dbg_state, 0);

    // Test 2: basic fetch
    pc_able = 1; pc_date = 32'h1C000000; ic_req_ready = 1;
    next_cyc();
    pc_able = 0;
    check_eq("t2_req_able", ic_req_able, 1);
    check_eq("t2_req_addr", ic_req_addr, 32'h1C000000);
    check_eq("t2_stop_c1", pc_stop, 1);
    next_cyc();
    ic_resp_able = 1; ic_resp_inst = 32'h02800000;
    check_eq("t2_stop_c2", pc_stop, 1);
    check_eq("t2_req_drop", ic_req_able, 0);
    next_cyc();
    ic_resp_able = 0;
    check_eq("t2_fetch_able", fetch_able, 1);
    check_eq("t2_fetch_pc", fetch_pc, 32'h1C000000);
    check_eq("t2_fetch_inst", fetch_inst, 32'h02800000);
    check_eq("t2_stop_c3", pc_stop, 1);
    next_cyc();
    check_eq("t2_idle_fa", fetch_able, 0);
    check_eq("t2_idle_stop", pc_stop, 0);
    check_eq("t2_keep_pc", fetch_pc, 32'h1C000000);

    // Test 3: request backpressure then decode stall
    pc_able = 1; pc_date = 32'h1C000040; ic_req_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      next_cyc();
      pc_able = 0;
      check_eq("t3_req_hold", ic_req_able, 1);
      check_eq("t3_addr_hold", ic_req_addr, 32'h1C000040);
      if (i == 4) ic_req_ready = 1;
    end
    next_cyc();
    ic_resp_able = 1; ic_resp_inst = 32'hA5A50013; dec_stall = 1;
    check_eq("t3_wait", dbg_state, 2);
    for (int i = 0; i < 2; i++) begin
      next_cyc();
      ic_resp_able = 0;
      check_eq("t3_stall_fa", fetch_able, 1);
      check_eq("t3_stall_pc", fetch_pc, 32'h1C000040);
      check_eq("t3_stall_inst", fetch_inst, 32'hA5A50013);
    end
    next_cyc();
    dec_stall = 0;
    check_eq("t3_release_fa", fetch_able, 1);
    next_cyc();
    check_eq("t3_idle", pc_stop, 0);

    // Test 4: flush while waiting for the response
    pc_able = 1; pc_date = 32'h1C000080; ic_req_ready = 1;
    next_cyc();
    pc_able = 0;
    next_cyc();
    flush_able = 1;
    next_cyc();
    flush_able = 0; ic_resp_able = 1; ic_resp_inst = 32'hDEADBEEF;
    check_eq("t4_still_wait", pc_stop, 1);
    next_cyc();
    ic_resp_able = 0;
    check_eq("t4_no_fetch", fetch_able, 0);
    check_eq("t4_idle", pc_stop, 0);
    pc_able = 1; pc_date = 32'h1C000100;
    next_cyc();
    pc_able = 0;
    check_eq("t4_next_addr", ic_req_addr, 32'h1C000100);
    next_cyc();
    ic_resp_able = 1; ic_resp_inst = 32'h00000013;
    next_cyc();
    ic_resp_able = 0;
    check_eq("t4_next_fa", fetch_able, 1);
    check_eq("t4_next_pc", fetch_pc, 32'h1C000100);
    check_eq("t4_next_inst", fetch_inst, 32'h00000013);
    next_cyc();

    // Test 5a: flush in REQ before acceptance -> withdraw
    pc_able = 1; pc_date = 32'h1C000200; ic_req_ready = 0;
    next_cyc();
    pc_able = 0; flush_able = 1;
    check_eq("t5a_req", ic_req_able, 1);
    next_cyc();
    flush_able = 0;
    check_eq("t5a_idle", pc_stop, 0);
    check_eq("t5a_no_req", ic_req_able, 0);
    // Test 5b: flush in REQ on the accepting edge -> wait, then drop
    pc_able = 1; pc_date = 32'h1C000300; ic_req_ready = 1;
    next_cyc();
    pc_able = 0; flush_able = 1;
    check_eq("t5b_req", ic_req_able, 1);
    next_cyc();
    flush_able = 0; ic_resp_able = 1; ic_resp_inst = 32'h11111111;
    check_eq("t5b_wait", dbg_state, 2);
    next_cyc();
    ic_resp_able = 0;
    check_eq("t5b_dropped", fetch_able, 0);
    check_eq("t5b_idle", pc_stop, 0);

    // Test 6: reset while holding with decode stalled
    pc_able = 1; pc_date = 32'h1C000400; ic_req_ready = 1;
    next_cyc();
    pc_able = 0;
    next_cyc();
    ic_resp_able = 1; ic_resp_inst = 32'h22222222; dec_stall = 1;
    next_cyc();
    ic_resp_able = 0;
    check_eq("t6_hold", fetch_able, 1);
    rest = 0;
    next_cyc();
    check_eq("t6_fa", fetch_able, 0);
    check_eq("t6_stop", pc_stop, 0);
    check_eq("t6_state", dbg_state, 0);
    check_eq("t6_fpc", fetch_pc, 0);
    rest = 1; dec_stall = 0;
    next_cyc();

    // Randomized run with a delayed ICache responder
    r_pend = 0; r_lat = 0; r_inst = '0;
    for (int c = 0; c < 4000; c++) begin
      next_cyc();
      ic_resp_able = 0;
      if (r_pend) begin
        if (r_lat == 0) begin
          ic_resp_able = 1;
          ic_resp_inst = r_inst;
          r_pend = 0;
        end else begin
          r_lat--;
        end
      end
      pc_able      = (c < 3950) && ($urandom_range(0, 3) != 0);
      pc_date      = $urandom & 32'hFFFF_FFFC;
      ic_req_ready = ($urandom_range(0, 2) != 0);
      flush_able   = (c < 3950) && ($urandom_range(0, 9) == 0);
      dec_stall    = ($urandom_range(0, 2) == 0);
      if (ic_req_able && ic_req_ready) begin
        check_eq("one_outstanding", r_pend, 0);
        r_pend = 1;
        r_lat  = $urandom_range(0, 2);
        r_inst = $urandom;
      end
    end
    idle_inputs();
    next_cyc(); next_cyc();
    check_eq("drain_idle", pc_stop, 0);
    check_eq("sb_empty", exp_q.size(), 0);
    check_eq("deliveries_seen", n_deliv > 50, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
